// File: rtl/m_store_buffer_pkg.sv
// Shared store-buffer types: store op encodings, byte-enable constants, queued entry layout.
// Latency: n/a (types only).
// Backpressure: n/a.
package m_store_buffer_pkg;

    typedef enum logic [1:0] {
        ST_SW  = 2'd0,
        ST_SH  = 2'd1,
        ST_SB  = 2'd2,
        ST_RSV = 2'd3
    } st_op_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    localparam int SB_ADDR_W = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [31:0]          wdata;
        logic [3:0]           be;
    } sb_entry_t;

endpackage

// File: rtl/m_store_buffer_store_align.sv
// Narrows a register value into lane-replicated write data and byte enables; flags misalignment.
// Latency: purely combinational.
// Backpressure: none.
module m_store_buffer_store_align
    import m_store_buffer_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misalign
);

    always_comb begin
        wdata    = data;
        be       = 4'b0000;
        misalign = 1'b0;
        case (st_op_e'(op))
            ST_SW: begin
                be       = BE_WORD;
                misalign = (addr_lo != 2'b00);
            end
            ST_SH: begin
                wdata    = {2{data[15:0]}};
                be       = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                misalign = addr_lo[0];
            end
            ST_SB: begin
                wdata = {4{data[7:0]}};
                be    = BE_BYTE0 << addr_lo;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/m_store_buffer.sv
// M-stage store buffer: aligns SW/SH/SB stores, queues them, drains in order to the data bus.
// Latency: 1 cycle from accepted store to bus_valid; no bypass.
// Backpressure: st_ready drops when full (no ready-through-dequeue); head holds until bus_ready.
module m_store_buffer
    import m_store_buffer_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = SB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [1:0]        st_op,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic              st_flush,
    output logic              st_ready,
    output logic              st_exc,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_conflict,
    output logic              bus_valid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ready,
    output logic              sb_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t          mem [DEPTH];
    logic [DEPTH-1:0]   ent_vld;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [31:0]        al_wdata;
    logic [3:0]         al_be;
    logic               al_misalign;
    logic               op_ok;
    logic               enq;
    logic               deq;
    sb_entry_t          new_ent;
    sb_entry_t          head;
    logic               unused_ld_lsb;

    m_store_buffer_store_align u_store_align (
        .op       (st_op),
        .addr_lo  (st_addr[1:0]),
        .data     (st_data),
        .wdata    (al_wdata),
        .be       (al_be),
        .misalign (al_misalign)
    );

    assign op_ok    = (st_op != ST_RSV);
    assign st_exc   = st_valid & op_ok & al_misalign;
    assign st_ready = (count < CNT_W'(DEPTH));
    assign enq      = st_valid & op_ok & st_ready & ~al_misalign & ~st_flush;
    assign bus_valid = (count != '0);
    assign sb_empty  = (count == '0);
    assign deq      = bus_valid & bus_ready;

    assign new_ent.addr  = {st_addr[ADDR_W-1:2], 2'b00};
    assign new_ent.wdata = al_wdata;
    assign new_ent.be    = al_be;

    // Bus outputs come straight from registered storage so they stay stable until dequeue.
    assign head      = mem[rd_ptr];
    assign bus_addr  = head.addr;
    assign bus_wdata = head.wdata;
    assign bus_be    = head.be;

    // Word-granular compare; the byte offset of the load is irrelevant.
    assign unused_ld_lsb = ^ld_addr[1:0];

    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (mem[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
                ld_conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Read and write slots never coincide: deq needs count>0, enq needs count<DEPTH.
            if (deq) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            if (enq) begin
                mem[wr_ptr]     <= new_ent;
                ent_vld[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (enq && !deq) begin
                count <= count + CNT_W'(1);
            end else if (deq && !enq) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_m_store_buffer.sv
// Directed bench for m_store_buffer with a scoreboard queue and a bus-side monitor.
module tb_m_store_buffer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_flush;
    logic        st_ready;
    logic        st_exc;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic        sb_empty;

    int   checks;
    int   errors;
    exp_t sb_q[$];

    m_store_buffer #(.DEPTH(2), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_op       (st_op),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_flush    (st_flush),
        .st_ready    (st_ready),
        .st_exc      (st_exc),
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict),
        .bus_valid   (bus_valid),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_ready   (bus_ready),
        .sb_empty    (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one store expected to be accepted at the next edge; its bus image goes to the scoreboard.
    task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_be);
        exp_t e;
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = addr;
        st_data  = data;
        e.addr   = e_addr;
        e.wdata  = e_wdata;
        e.be     = e_be;
        sb_q.push_back(e);
        step();
        st_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus_ready = 1'b1;
        while (!sb_empty && n < 10) begin
            step();
            n++;
        end
        bus_ready = 1'b0;
        check("drain_empty", {31'd0, sb_empty}, 32'd1);
    endtask

    // Monitor: a handshake seen mid-cycle completes at the next edge, so pop and compare now.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus_valid && bus_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_bus_beat", bus_addr, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("bus_addr", bus_addr, e.addr);
                    check("bus_wdata", bus_wdata, e.wdata);
                    check("bus_be", {28'd0, bus_be}, {28'd0, e.be});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        st_valid  = 1'b0;
        st_op     = 2'd0;
        st_addr   = 32'd0;
        st_data   = 32'd0;
        st_flush  = 1'b0;
        ld_addr   = 32'd0;
        bus_ready = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        check("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
        check("rst_st_ready", {31'd0, st_ready}, 32'd1);
        check("rst_ld_conflict", {31'd0, ld_conflict}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", {28'd0, bus_be}, 32'd0);
        rst_n = 1'b1;
        step();

        // SB at byte 3: no bypass in request cycle, head visible one cycle later
        st_valid = 1'b1; st_op = 2'd2; st_addr = 32'h1003; st_data = 32'h1234_56AB;
        #1;
        check("sb_no_exc", {31'd0, st_exc}, 32'd0);
        check("sb_no_bypass", {31'd0, bus_valid}, 32'd0);
        send(2'd2, 32'h1003, 32'h1234_56AB, 32'h1000, 32'hABAB_ABAB, 4'b1000);
        check("sb_head_valid", {31'd0, bus_valid}, 32'd1);
        check("sb_head_addr", bus_addr, 32'h1000);
        check("sb_head_be", {28'd0, bus_be}, 32'h8);
        check("sb_not_empty", {31'd0, sb_empty}, 32'd0);
        drain();

        // SH upper half, then misaligned SH / SW and reserved op
        send(2'd1, 32'h2002, 32'hFFFF_8001, 32'h2000, 32'h8001_8001, 4'b1100);
        drain();
        st_valid = 1'b1; st_op = 2'd1; st_addr = 32'h2001; st_data = 32'h5555_AAAA;
        #1;
        check("sh_exc", {31'd0, st_exc}, 32'd1);
        st_op = 2'd0; st_addr = 32'h2002;
        #1;
        check("sw_exc", {31'd0, st_exc}, 32'd1);
        step();
        check("exc_no_enq", {31'd0, sb_empty}, 32'd1);
        st_op = 2'd3; st_addr = 32'h2001;
        #1;
        check("rsv_no_exc", {31'd0, st_exc}, 32'd0);
        step();
        st_valid = 1'b0;
        check("rsv_no_enq", {31'd0, sb_empty}, 32'd1);

        // Fill, hold a third request, partial drain, then simultaneous enq/deq across wrap
        send(2'd0, 32'h4000, 32'h1111_1111, 32'h4000, 32'h1111_1111, 4'b1111);
        send(2'd0, 32'h4004, 32'h2222_2222, 32'h4004, 32'h2222_2222, 4'b1111);
        check("full_not_ready", {31'd0, st_ready}, 32'd0);
        st_valid = 1'b1; st_op = 2'd0; st_addr = 32'h4008; st_data = 32'h3333_3333;
        step();
        st_valid = 1'b0;
        check("full_head_held", bus_addr, 32'h4000);
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        check("one_left_ready", {31'd0, st_ready}, 32'd1);
        check("head_second", bus_addr, 32'h4004);
        check("head_second_dat", bus_wdata, 32'h2222_2222);
        bus_ready = 1'b1;
        send(2'd0, 32'h4008, 32'h3333_3333, 32'h4008, 32'h3333_3333, 4'b1111);
        bus_ready = 1'b0;
        check("simul_still_one", {31'd0, st_ready}, 32'd1);
        check("simul_head_wrap", bus_addr, 32'h4008);
        send(2'd2, 32'h400D, 32'h0000_00C3, 32'h400C, 32'hC3C3_C3C3, 4'b0010);
        st_valid = 1'b1; st_op = 2'd0; st_addr = 32'h4010; st_data = 32'h4444_4444;
        bus_ready = 1'b1;
        #1;
        check("full_no_ready_through", {31'd0, st_ready}, 32'd0);
        step();
        st_valid = 1'b0;
        drain();

        // Load-address conflict against a queued word
        send(2'd0, 32'h3000, 32'hDEAD_BEEF, 32'h3000, 32'hDEAD_BEEF, 4'b1111);
        ld_addr = 32'h3002;
        #1;
        check("conflict_same_word", {31'd0, ld_conflict}, 32'd1);
        ld_addr = 32'h3004;
        #1;
        check("conflict_next_word", {31'd0, ld_conflict}, 32'd0);
        ld_addr = 32'h3000;
        bus_ready = 1'b1;
        #1;
        check("conflict_leaving", {31'd0, ld_conflict}, 32'd1);
        drain();
        check("conflict_after_drain", {31'd0, ld_conflict}, 32'd0);

        // Flushed request, then async reset with two entries queued
        st_valid = 1'b1; st_op = 2'd0; st_addr = 32'h5000; st_data = 32'h5A5A_5A5A; st_flush = 1'b1;
        step();
        st_valid = 1'b0; st_flush = 1'b0;
        check("flush_no_enq", {31'd0, sb_empty}, 32'd1);
        send(2'd0, 32'h6000, 32'h6666_6666, 32'h6000, 32'h6666_6666, 4'b1111);
        send(2'd1, 32'h6006, 32'h0000_7777, 32'h6004, 32'h7777_7777, 4'b1100);
        check("pre_rst_full", {31'd0, st_ready}, 32'd0);
        ld_addr = 32'h6004;
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("arst_empty", {31'd0, sb_empty}, 32'd1);
        check("arst_bus_valid", {31'd0, bus_valid}, 32'd0);
        check("arst_ready", {31'd0, st_ready}, 32'd1);
        check("arst_conflict", {31'd0, ld_conflict}, 32'd0);
        check("arst_bus_addr", bus_addr, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_empty", {31'd0, sb_empty}, 32'd1);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
